// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Request/result bundle between EX-stage control and the
//               iterative multiply/divide engine.
//               master : start, op, op1, op2, flush  ->  engine
//               slave  : busy, done, div_by_zero, hi, lo  ->  requester
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op1, op2, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, op1, op2, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative radix-2 multiply/divide engine with HI/LO results.
//               Ops: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
//               One bit is processed per clock, so an operation spends
//               WIDTH cycles in RUN. Signed ops iterate on magnitudes and
//               fix the sign once at the end.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous reset, active low
//               bus    - slave side of muldiv_sequencer_if
//                        (start/op/op1/op2/flush in,
//                         busy/done/div_by_zero/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;       // multiplicand (mult) or divisor (div) magnitude
    logic [WIDTH-1:0] r_acc;     // upper product half (mult) or partial remainder (div)
    logic [WIDTH-1:0] r_q;       // multiplier shifting out (mult) or dividend->quotient (div)
    logic             r_is_div;
    logic             r_neg_res; // operand signs differ on a signed op
    logic             r_neg_rem; // signed divide with negative dividend
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // ------------------------------------------------------------------
    // Operand magnitudes at accept time
    // ------------------------------------------------------------------
    logic             w_signed_op;
    logic             w_is_div;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_accept;

    assign w_signed_op = ~bus.op[0];
    assign w_is_div    = bus.op[1];
    assign w_mag1      = (w_signed_op && bus.op1[WIDTH-1]) ? (~bus.op1 + 1'b1) : bus.op1;
    assign w_mag2      = (w_signed_op && bus.op2[WIDTH-1]) ? (~bus.op2 + 1'b1) : bus.op2;
    // flush wins over a coincident start
    assign w_accept    = bus.start && !bus.flush;

    // ------------------------------------------------------------------
    // One radix-2 step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_m_acc;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_sub;
    logic               w_fits;
    logic [WIDTH-1:0]   w_next_acc;
    logic [WIDTH-1:0]   w_next_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    always_comb begin
        w_sum   = {1'b0, r_acc} + {1'b0, r_a};
        w_m_acc = r_q[0] ? w_sum : {1'b0, r_acc};
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_fits  = (w_shift >= {1'b0, r_a});
        // Partial remainder stays below the divisor, so the difference
        // always fits in WIDTH bits when it is taken.
        w_sub   = w_shift[WIDTH-1:0] - r_a;

        if (r_is_div) begin
            w_next_acc = w_fits ? w_sub : w_shift[WIDTH-1:0];
            w_next_q   = {r_q[WIDTH-2:0], w_fits};
        end else begin
            // {acc, q} shifts right one place with the adder carry entering on top
            w_next_acc = w_m_acc[WIDTH:1];
            w_next_q   = {w_m_acc[0], r_q[WIDTH-1:1]};
        end

        w_prod = {w_next_acc, w_next_q};
        if (r_neg_res) begin
            w_prod = ~w_prod + 1'b1;
        end

        if (r_is_div) begin
            w_fin_lo = r_neg_res ? (~w_next_q + 1'b1) : w_next_q;
            w_fin_hi = r_neg_rem ? (~w_next_acc + 1'b1) : w_next_acc;
        end else begin
            w_fin_lo = w_prod[WIDTH-1:0];
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_dbz     <= 1'b0;
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_signed_op & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
                        r_neg_rem <= w_signed_op & bus.op1[WIDTH-1];
                        if (w_is_div && (bus.op2 == '0)) begin
                            // No iteration: report immediately, hi/lo untouched
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(WIDTH-1);
                            r_acc   <= '0;
                            r_a     <= w_is_div ? w_mag2 : w_mag1;
                            r_q     <= w_is_div ? w_mag1 : w_mag2;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_next_acc;
                        r_q   <= w_next_q;
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_hi    <= w_fin_hi;
                            r_lo    <= w_fin_lo;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. Expected results
//               come from plain 64-bit arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();
    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural HI/LO as the model believes them to be
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    // Reference model: updates exp_hi/exp_lo like the ISA would
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic dbz);
        longint      sp, sq, sr;
        logic [63:0] up;
        dbz = 1'b0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                exp_hi = up[63:32];
                exp_lo = up[31:0];
            end
            2'b10: begin
                if (b == 0) dbz = 1'b1;
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    exp_lo = sq[31:0];
                    exp_hi = sr[31:0];
                end
            end
            default: begin
                if (b == 0) dbz = 1'b1;
                else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
        endcase
    endtask

    // Drive one request and wait (bounded) for done; returns at the
    // negedge of the done cycle. cycles = cycles from accept to done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output int busy_cycles);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.op1 = a; bus.op2 = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cycles++;
            if (bus.done) break;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.op1 = '0; bus.op2 = '0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        n_tests++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] as  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                                 32'd7, 32'h80000000, 32'd100};
        logic [31:0] bs  [7] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd2,
                                 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF9};
        int cyc, bcyc;
        logic dbz;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], cyc, bcyc);
            model(ops[i], as[i], bs[i], dbz);
            n_tests++;
            if (cyc !== 33 || bcyc !== 32) begin
                n_fail++; $display("FAIL dir%0d_latency: got done@%0d busy=%0d want 33/32", i, cyc, bcyc);
            end
            n_tests++;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.div_by_zero !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_result: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=0",
                                   i, bus.hi, bus.lo, bus.div_by_zero, exp_hi, exp_lo);
            end
        end
        // Fixed expectations for the all-ones unsigned product
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcyc);
        model(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, dbz);
        n_tests++;
        if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
            n_fail++; $display("FAIL multu_max: got hi=%h lo=%h want fffffffe/00000001", bus.hi, bus.lo);
        end
    endtask

    task automatic test_random();
        int cyc, bcyc;
        logic dbz;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            run_op(op, a, b, cyc, bcyc);
            model(op, a, b, dbz);
            n_tests++;
            if (cyc !== (dbz ? 1 : 33) || bcyc !== (dbz ? 0 : 32)) begin
                n_fail++; $display("FAIL rnd%0d_latency: op=%0d got done@%0d busy=%0d", i, op, cyc, bcyc);
            end
            n_tests++;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.div_by_zero !== dbz) begin
                n_fail++; $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                                   i, op, a, b, bus.hi, bus.lo, bus.div_by_zero, exp_hi, exp_lo, dbz);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int cyc, bcyc;
        logic dbz;
        run_op(2'b11, 32'd7, 32'd2, cyc, bcyc);
        model(2'b11, 32'd7, 32'd2, dbz);
        run_op(2'b10, 32'd5, 32'd0, cyc, bcyc);
        model(2'b10, 32'd5, 32'd0, dbz);
        n_tests++;
        if (cyc !== 1 || bus.div_by_zero !== 1'b1 || bcyc !== 0) begin
            n_fail++; $display("FAIL dbz_timing: got done@%0d dbz=%b busy=%0d want 1/1/0",
                               cyc, bus.div_by_zero, bcyc);
        end
        n_tests++;
        if (bus.hi !== 32'd1 || bus.lo !== 32'd3) begin
            n_fail++; $display("FAIL dbz_hold: got hi=%h lo=%h want 1/3", bus.hi, bus.lo);
        end
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL dbz_pulse: got done=%b want 0", bus.done);
        end
    endtask

    task automatic test_flush();
        logic saw_done;
        // flush and start together in IDLE: start must be dropped
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.op1 = 32'd9; bus.op2 = 32'd9;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL flush_start: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        // flush 10 cycles into RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.op1 = 32'h1234; bus.op2 = 32'h5678;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_prebusy: got busy=%b want 1", bus.busy);
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy: got busy=%b want 0", bus.busy);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            n_fail++; $display("FAIL flush_hold: got activity=%b hi=%h lo=%h want 0 hi=%h lo=%h",
                               saw_done, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.op1 = 32'hDEAD; bus.op2 = 32'hBEEF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        logic dbz;
        run_op(2'b01, 32'd2, 32'd3, cyc, bcyc);
        model(2'b01, 32'd2, 32'd3, dbz);
        n_tests++;
        if (bus.done !== 1'b1 || bus.lo !== 32'd6) begin
            n_fail++; $display("FAIL b2b_first: got done=%b lo=%h want 1/6", bus.done, bus.lo);
        end
        // start in the DONE cycle
        bus.start = 1'b1; bus.op = 2'b01; bus.op1 = 32'd4; bus.op2 = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept: got done=%b busy=%b want 0/1", bus.done, bus.busy);
        end
        // start during RUN must be ignored
        bus.start = 1'b1; bus.op = 2'b01; bus.op1 = 32'd100; bus.op2 = 32'd100;
        cyc = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 6) bus.start = 1'b0;
            if (bus.done) break;
        end
        model(2'b01, 32'd4, 32'd5, dbz);
        n_tests++;
        if (cyc !== 33 || bus.lo !== 32'd20 || bus.hi !== 32'd0) begin
            n_fail++; $display("FAIL b2b_second: got done@%0d hi=%h lo=%h want 33 0/20", cyc, bus.hi, bus.lo);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_queue: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_div_by_zero();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
